// File: rtl/jesd204_tx_lane_seq.sv
// Per-lane JESD204B transmit sequencer: /K/ code-group sync, LMFC-aligned ILAS, then user data.
// Output data and K flags are registered; tx_ready is combinational from the state register.
module jesd204_tx_lane_seq #(
  parameter int DATA_PATH_WIDTH  = 4,
  parameter int ILAS_MULTIFRAMES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sync_n,
  input  logic                         lmfc_edge,
  input  logic [7:0]                   cfg_beats_per_multiframe,
  input  logic                         cfg_skip_ilas,
  input  logic [111:0]                 ilas_config_data,
  input  logic [8*DATA_PATH_WIDTH-1:0] tx_data,
  output logic                         tx_ready,
  output logic [8*DATA_PATH_WIDTH-1:0] phy_data,
  output logic [DATA_PATH_WIDTH-1:0]   phy_charisk,
  output logic [1:0]                   status_state
);

  localparam int              DW      = 8 * DATA_PATH_WIDTH;
  localparam logic [7:0]      LAST_MF = 8'(ILAS_MULTIFRAMES - 1);
  localparam logic [DW-1:0]   K_CHARS = {DATA_PATH_WIDTH{8'hBC}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t                     state, state_nxt;
  logic [7:0]                 beat_cnt, beat_nxt;
  logic [7:0]                 mf_cnt, mf_nxt;
  logic [DW-1:0]              data_nxt;
  logic [DATA_PATH_WIDTH-1:0] k_nxt;
  logic [DW-1:0]              ilas_data;
  logic [DATA_PATH_WIDTH-1:0] ilas_k;
  logic                       last_beat;

  assign last_beat    = (beat_cnt == cfg_beats_per_multiframe);
  assign tx_ready     = (state == ST_DATA) && sync_n && enable;
  assign status_state = state;

  // ILAS beat: ramp by default, with R/Q/A markers and the config block overlaid in multiframe 1.
  always_comb begin
    ilas_k = '0;
    for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
      ilas_data[8*i +: 8] = {beat_cnt[5:0], i[1:0]};
    end
    if (beat_cnt == 8'd0) begin
      ilas_data[7:0] = 8'h1C;
      ilas_k[0]      = 1'b1;
    end
    if (mf_cnt == 8'd1) begin
      case (beat_cnt)
        8'd0: begin
          ilas_data[15:8]  = 8'h9C;
          ilas_k[1]        = 1'b1;
          ilas_data[31:16] = ilas_config_data[15:0];
        end
        8'd1:    ilas_data[31:0] = ilas_config_data[47:16];
        8'd2:    ilas_data[31:0] = ilas_config_data[79:48];
        8'd3:    ilas_data[31:0] = ilas_config_data[111:80];
        default: ;
      endcase
    end
    if (last_beat) begin
      ilas_data[31:24] = 8'h7C;
      ilas_k[3]        = 1'b1;
    end
  end

  // Next state and the beat to load; enable low wins over everything, sync_n low falls back to CGS.
  always_comb begin
    state_nxt = state;
    beat_nxt  = 8'd0;
    mf_nxt    = 8'd0;
    data_nxt  = '0;
    k_nxt     = '0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CGS;
        ST_CGS: begin
          data_nxt = K_CHARS;
          k_nxt    = '1;
          if (sync_n && lmfc_edge) begin
            state_nxt = cfg_skip_ilas ? ST_DATA : ST_ILAS;
          end
        end
        ST_ILAS: begin
          if (!sync_n) begin
            state_nxt = ST_CGS;
            data_nxt  = K_CHARS;
            k_nxt     = '1;
          end else begin
            data_nxt = ilas_data;
            k_nxt    = ilas_k;
            if (last_beat) begin
              if (mf_cnt == LAST_MF) begin
                state_nxt = ST_DATA;
              end else begin
                mf_nxt = mf_cnt + 8'd1;
              end
            end else begin
              beat_nxt = beat_cnt + 8'd1;
              mf_nxt   = mf_cnt;
            end
          end
        end
        ST_DATA: begin
          if (!sync_n) begin
            state_nxt = ST_CGS;
            data_nxt  = K_CHARS;
            k_nxt     = '1;
          end else begin
            data_nxt = tx_data;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      beat_cnt    <= 8'd0;
      mf_cnt      <= 8'd0;
      phy_data    <= '0;
      phy_charisk <= '0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_nxt;
      mf_cnt      <= mf_nxt;
      phy_data    <= data_nxt;
      phy_charisk <= k_nxt;
    end
  end

endmodule

// File: tb/tb_jesd204_tx_lane_seq.sv
// Directed bench for jesd204_tx_lane_seq: a vector table for reset/CGS/ILAS entry,
// then hand-written sequences for the full ILAS, DATA, re-sync, enable drop and skip-ILAS.
module tb_jesd204_tx_lane_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         sync_n;
  logic         lmfc_edge;
  logic [7:0]   cfg_beats_per_multiframe;
  logic         cfg_skip_ilas;
  logic [111:0] ilas_config_data;
  logic [31:0]  tx_data;
  logic         tx_ready;
  logic [31:0]  phy_data;
  logic [3:0]   phy_charisk;
  logic [1:0]   status_state;

  int total_checks  = 0;
  int passed_checks = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        sn;
    logic        lmfc;
    logic [31:0] td;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    logic [1:0]  e_state;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  jesd204_tx_lane_seq #(
    .DATA_PATH_WIDTH (4),
    .ILAS_MULTIFRAMES(4)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .sync_n                  (sync_n),
    .lmfc_edge               (lmfc_edge),
    .cfg_beats_per_multiframe(cfg_beats_per_multiframe),
    .cfg_skip_ilas           (cfg_skip_ilas),
    .ilas_config_data        (ilas_config_data),
    .tx_data                 (tx_data),
    .tx_ready                (tx_ready),
    .phy_data                (phy_data),
    .phy_charisk             (phy_charisk),
    .status_state            (status_state)
  );

  always #5 clk = ~clk;

  // One cycle: inputs change just after the rising edge, outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic rst, input logic en, input logic sn,
                               input logic lmfc, input logic [31:0] td);
    @(posedge clk);
    #1;
    reset     = rst;
    enable    = en;
    sync_n    = sn;
    lmfc_edge = lmfc;
    tx_data   = td;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic chk_data, input logic [31:0] e_data,
                             input logic [3:0] e_k, input logic [1:0] e_state, input logic e_ready);
    logic ok;
    ok = (status_state === e_state) && (tx_ready === e_ready);
    if (chk_data) ok = ok && (phy_data === e_data) && (phy_charisk === e_k);
    total_checks++;
    if (ok) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got data=%h k=%h state=%0d ready=%b, want data=%h k=%h state=%0d ready=%b",
               name, phy_data, phy_charisk, status_state, tx_ready, e_data, e_k, e_state, e_ready);
    end
  endtask

  function automatic void addVec(string n, logic rst, logic en, logic sn, logic lmfc, logic [31:0] td,
                                 logic [31:0] e_data, logic [3:0] e_k, logic [1:0] e_state, logic e_ready);
    vec_t v;
    v.name = n;     v.rst = rst;       v.en = en;         v.sn = sn;           v.lmfc = lmfc;
    v.td = td;      v.e_data = e_data; v.e_k = e_k;       v.e_state = e_state; v.e_ready = e_ready;
    vecs.push_back(v);
  endfunction

  initial begin
    logic        e_chk;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    logic [1:0]  e_state;
    logic        e_ready;

    reset                    = 1'b1;
    enable                   = 1'b1;
    sync_n                   = 1'b0;
    lmfc_edge                = 1'b0;
    tx_data                  = 32'h0;
    cfg_beats_per_multiframe = 8'd7;
    cfg_skip_ilas            = 1'b0;
    for (int i = 0; i < 14; i++) ilas_config_data[8*i +: 8] = 8'hA0 + 8'(i);

    addVec("reset_c0",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        4'h0, 2'd0, 1'b0);
    addVec("reset_c1",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        4'h0, 2'd0, 1'b0);
    addVec("reset_c2",         1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        4'h0, 2'd0, 1'b0);
    addVec("idle_release",     1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        4'h0, 2'd0, 1'b0);
    addVec("cgs_entry",        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0,        4'h0, 2'd1, 1'b0);
    addVec("cgs_k28_5",        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    addVec("cgs_sync_no_lmfc", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    addVec("cgs_lmfc_n",       1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    addVec("ilas_n_plus_1",    1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hBCBCBCBC, 4'hF, 2'd2, 1'b0);
    addVec("ilas_r_n_plus_2",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0302011C, 4'h1, 2'd2, 1'b0);
    addVec("ilas_b1_lmfc_ign", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h07060504, 4'h0, 2'd2, 1'b0);

    foreach (vecs[j]) begin
      applyStimulus(vecs[j].rst, vecs[j].en, vecs[j].sn, vecs[j].lmfc, vecs[j].td);
      checkOutput(vecs[j].name, 1'b1, vecs[j].e_data, vecs[j].e_k, vecs[j].e_state, vecs[j].e_ready);
    end

    // Remaining ILAS beats 2..31; user data is offered on the cycle the last beat is showing.
    for (int k = 2; k <= 31; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, (k == 31) ? 32'h12345678 : 32'h0);
      e_chk   = 1'b1;
      e_state = 2'd2;
      e_ready = 1'b0;
      e_k     = 4'h0;
      case (k)
        2:       e_data = 32'h0B0A0908;
        7:  begin e_data = 32'h7C1E1D1C; e_k = 4'h8; end
        8:  begin e_data = 32'hA1A09C1C; e_k = 4'h3; end
        9:       e_data = 32'hA5A4A3A2;
        10:      e_data = 32'hA9A8A7A6;
        11:      e_data = 32'hADACABAA;
        12:      e_data = 32'h13121110;
        15: begin e_data = 32'h7C1E1D1C; e_k = 4'h8; end
        16: begin e_data = 32'h0302011C; e_k = 4'h1; end
        24: begin e_data = 32'h0302011C; e_k = 4'h1; end
        31: begin e_data = 32'h7C1E1D1C; e_k = 4'h8; e_state = 2'd3; e_ready = 1'b1; end
        default: begin e_data = 32'h0; e_chk = 1'b0; end
      endcase
      checkOutput($sformatf("ilas_beat_%0d", k), e_chk, e_data, e_k, e_state, e_ready);
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
    checkOutput("data_first", 1'b1, 32'h12345678, 4'h0, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("data_sync_drop", 1'b1, 32'hCAFEF00D, 4'h0, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resync_cgs", 1'b1, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resync_wait_lmfc", 1'b1, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    checkOutput("resync_lmfc", 1'b1, 32'hBCBCBCBC, 4'hF, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resync_ilas", 1'b1, 32'hBCBCBCBC, 4'hF, 2'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("resync_r", 1'b1, 32'h0302011C, 4'h1, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Enable drops while ILAS beat 5 is being prepared (beat 4 is on the wire).
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("ilas_b5_en_drop", 1'b1, 32'h13121110, 4'h0, 2'd2, 1'b0);
    cfg_skip_ilas = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("idle_zeros", 1'b1, 32'h0, 4'h0, 2'd0, 1'b0);

    // Skip-ILAS: CGS goes directly to DATA, no R/Q/A beats.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("skip_idle", 1'b1, 32'h0, 4'h0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    checkOutput("skip_cgs", 1'b1, 32'h0, 4'h0, 2'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h11223344);
    checkOutput("skip_data_state", 1'b1, 32'hBCBCBCBC, 4'hF, 2'd3, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h55667788);
    checkOutput("skip_first_beat", 1'b1, 32'h11223344, 4'h0, 2'd3, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("after_reset", 1'b1, 32'h0, 4'h0, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_lane_seq.md
Name: jesd204_tx_lane_seq

Overview:
- Per-lane JESD204B transmit sequencer: the transmit-side counterpart of the receive lane elastic buffer and release logic.
- Emits code-group synchronisation (/K/), then a 4-multiframe initial lane alignment sequence (ILAS) aligned to the LMFC, then user data.
- Sits between the TX link-layer data path and the 8b10b/PHY interface, one instance per lane. All logic runs on the single link clock.

Parameters:
- DATA_PATH_WIDTH, 4: octets per beat. Fixed at 4; the data bus is 8*DATA_PATH_WIDTH bits.
- ILAS_MULTIFRAMES, 4: number of ILAS multiframes.

Ports:
- clk  input  1  link clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  lane enable; low forces IDLE.
- sync_n  input  1  SYNC~ from the receiver, already synchronised to clk; low requests CGS.
- lmfc_edge  input  1  single-cycle LMFC boundary strobe.
- cfg_beats_per_multiframe  input  8  beats per multiframe minus 1. Legal values are 4 to 255.
- cfg_skip_ilas  input  1  when 1, go from CGS straight to DATA.
- ilas_config_data  input  112  14 ILAS config octets; octet k is in bits [8k+7:8k].
- tx_data  input  32  user data; octet 0 is in [7:0] and is transmitted first.
- tx_ready  output  1  tx_data is consumed at this clock edge.
- phy_data  output  32  registered lane data.
- phy_charisk  output  4  per-octet K flag.
- status_state  output  2  current state: 0 IDLE, 1 CGS, 2 ILAS, 3 DATA.

Behaviour:
- Reset value of every output: phy_data=0, phy_charisk=0, tx_ready=0, status_state=0.
- Reset value of internal state: state IDLE, beat_cnt=0, mf_cnt=0.
- The state register and the counters describe the beat loaded into phy_data/phy_charisk at the next clk edge. Output latency is 1 cycle.
- IDLE:
  - Loads 0 into phy_data and 0 into phy_charisk.
  - Goes to CGS when enable=1.
- CGS:
  - Loads 0xBCBCBCBC into phy_data and 4'hF into phy_charisk.
  - When sync_n=1 and lmfc_edge=1 in the same cycle: goes to ILAS with beat_cnt=0, mf_cnt=0, or to DATA if cfg_skip_ilas=1.
  - Otherwise stays in CGS, including when sync_n=1 without lmfc_edge.
- ILAS, for beat b of multiframe m:
  - Default octet i = (4b+i) mod 256 with K=0 (ramp).
  - Beat 0 of every multiframe: octet 0 = 0x1C (K28.0, R) with K=1.
  - m=1 only: beat 0 octet 1 = 0x9C (K28.4, Q) with K=1; beat 0 octets 2-3 = cfg octets 0-1.
  - m=1 only: beats 1, 2 and 3 carry cfg octets 2-5, 6-9 and 10-13 respectively.
  - Last beat (b=cfg_beats_per_multiframe) of every multiframe: octet 3 = 0x7C (K28.3, A) with K=1.
  - Counter advance: beat_cnt increments and wraps to 0 after cfg_beats_per_multiframe, incrementing mf_cnt on the wrap.
  - On the last beat of multiframe ILAS_MULTIFRAMES-1, the next state is DATA.
- DATA:
  - tx_ready = (state==DATA) && sync_n && enable. This is combinational from the state register and inputs.
  - Loads tx_data with phy_charisk=0.
- sync_n=0 in ILAS or DATA: the next state is CGS and the next load is /K/. tx_data is not consumed because tx_ready=0. Counters clear.
- enable=0 in any state: the next state is IDLE and the next load is zeros. This takes priority over sync_n.
- reset=1 overrides everything in the same cycle.
- Mid-operation changes of cfg_* values are unsupported; software changes them only while in IDLE.
- Timing: with lmfc_edge sampled at cycle n in CGS, R appears on phy_data in cycle n+2. The first user beat appears 4*(cfg_beats_per_multiframe+1) cycles after R. This offset is identical on all lanes.
- lmfc_edge is ignored outside CGS.

Test Plan:
- Reset held 3 cycles with enable=1, then released with sync_n=0 -> phy_data=0 and charisk=0 during reset; then 0xBCBCBCBC / 4'hF from the second cycle after release; status_state=1.
- cfg_beats_per_multiframe=7, sync_n=1, lmfc_edge pulse at cycle n -> phy_data at n+2 is 0x0302011C with charisk 4'h1. Beat 7 of that multiframe is 0x7C1E1D1C with charisk 4'h8.
- Same config with ilas_config_data octets = 0xA0 to 0xAD -> multiframe 1 beat 0 = 0xA1A09C1C, charisk 4'h3; beat 3 = 0xADACABAA, charisk 0.
- After the 32nd ILAS beat -> tx_ready high; tx_data 0x12345678 appears on phy_data the next cycle with charisk 0; status_state=3.
- sync_n driven low mid-DATA -> tx_ready drops in the same cycle; next phy_data = 0xBCBCBCBC; status_state=1. Re-sync waits for lmfc_edge.
- cfg_skip_ilas=1, and separately enable dropped during ILAS beat 5 -> skip case: DATA is the first beat after CGS, no R/Q/A. Enable-drop case: IDLE with zeros on the next cycle.
